multi_sr04_ranger: RTL
======================

MULTI_SR04_RANGER -- requirements
Module: multi_sr04_ranger

Interface
REQ-001 Parameter CLK_FREQ_HZ, 50_000_000, system clock frequency; the 1 us tick divisor is CLK_FREQ_HZ/1_000_000.
REQ-002 Parameter NUM_CH, 4, number of HC-SR04 sensors, range 1..16.
REQ-003 Parameter TRIG_US, 10, trigger pulse width in us.
REQ-004 Parameter RISE_TO_US, 2000, maximum wait from trigger end to echo rise.
REQ-005 Parameter ECHO_TO_US, 38000, maximum echo high time; exceeding it is overrange.
REQ-006 Parameter GAP_US, 60000, idle time after each measurement before the next trigger.
REQ-007 Parameter DIST_W, 16, distance output width in mm.
REQ-008 sys_clk  input  1  single system clock; all logic is on its rising edge.
REQ-009 sys_rst  input  1  reset, synchronous and active-high.
REQ-010 en  input  1  enables scheduling; sampled only in IDLE.
REQ-011 echo  input  NUM_CH  asynchronous echo lines, one per sensor.
REQ-012 trig  output  NUM_CH  registered trigger pulses, one-hot or zero.
REQ-013 res_valid  output  1  a result is held on res_*.
REQ-014 res_ready  input  1  consumer accepts the result when res_valid && res_ready.
REQ-015 res_ch  output  max(1,$clog2(NUM_CH))  channel index of the result.
REQ-016 res_dist  output  DIST_W  distance in mm, saturated.
REQ-017 res_err  output  2  status: 00 ok, 01 no echo, 10 overrange.

Function
REQ-018 Each echo bit SHALL pass through a 2-flop synchroniser; only the synchronised value of the current channel is used.
REQ-019 us_tick SHALL pulse for one sys_clk cycle every CLK_FREQ_HZ/1e6 cycles; all us counts advance only on us_tick.
REQ-020 The FSM SHALL have states IDLE, TRIG, WAIT_RISE, MEASURE, CALC, OUT and GAP.
REQ-021 IDLE goes to TRIG when en=1, with current channel cur_ch kept (0 after reset).
REQ-022 TRIG SHALL drive trig[cur_ch]=1 for exactly TRIG_US ticks, then go to WAIT_RISE.
REQ-023 WAIT_RISE goes to MEASURE on the first synchronised echo=1.
REQ-024 WAIT_RISE goes to CALC with err=01 when RISE_TO_US ticks elapse with no echo.
REQ-025 MEASURE SHALL count ticks while echo=1.
REQ-026 MEASURE goes to CALC on echo falling with err=00.
REQ-027 MEASURE goes to CALC with err=10 when the count reaches ECHO_TO_US.
REQ-028 CALC SHALL compute dist = (echo_us * 11239) >> 16, i.e. 0.1715 mm/us, in one cycle with a full-width product; the result saturates to 2^DIST_W-1.
REQ-029 For err≠00, CALC SHALL set dist = all ones.
REQ-030 CALC SHALL load res_ch, res_dist and res_err, set res_valid=1 and go to OUT.
REQ-031 OUT SHALL hold res_* stable until res_valid && res_ready; in that cycle res_valid clears and the FSM goes to GAP (backpressure stalls the scheduler).
REQ-032 GAP SHALL wait GAP_US ticks and ignore all echoes.
REQ-033 At the end of GAP, cur_ch wraps to 0 after NUM_CH-1, otherwise increments; the FSM then goes to TRIG if en=1, else IDLE.
REQ-034 Deasserting en mid-measurement SHALL NOT abort it; the current result is still delivered.
REQ-035 An echo already high on entry to WAIT_RISE (stuck sensor) is treated as a rise; it then ends as overrange.
REQ-036 trig SHALL be zero in every state except TRIG.

Reset
REQ-037 sys_rst=1 SHALL force the following on the next edge, regardless of state: IDLE, cur_ch=0, trig=0, res_valid=0, res_ch=0, res_dist=0, res_err=00, all counters and synchronisers 0.
REQ-038 Reset during OUT SHALL discard the pending result.

Structure
REQ-039 Package sr04_pkg SHALL hold the FSM state enum, the error code constants (ERR_OK, ERR_NOECHO, ERR_RANGE) and the scale constant MM_PER_US_Q16=11239.
REQ-040 The tick generator SHALL be sub-module sr04_us_tick (sys_clk, sys_rst -> us_tick), parametrised by CLK_FREQ_HZ.
REQ-041 The design SHALL use one shared us counter, reused per state.

Verification (CLK_FREQ_HZ=50e6, NUM_CH=2, GAP_US=100)
REQ-042 en=1, ch0 echo high 1000 us -> trig[0] high 500 clks, then res_ch=0, res_dist=171, res_err=00.
REQ-043 ch1 echo high 5830 us -> res_ch=1, res_dist=999, err=00, then next trigger on ch0 (wrap).
REQ-044 no echo on ch0 -> result 2000 us after trig falls: res_dist=16'hFFFF, res_err=01.
REQ-045 echo held high -> res_err=10 after 38000 us, res_dist=16'hFFFF.
REQ-046 res_ready=0 for 1 ms -> res_* stable and no trig pulse; after res_ready=1 for 1 cycle, res_valid drops and GAP starts.
REQ-047 sys_rst=1 during MEASURE -> trig=0, res_valid=0; with en=1 the next trigger is on ch0.

Source files
------------

// File: rtl/sr04_pkg.sv
// Shared types and constants for the multi-sensor HC-SR04 ranger.
package sr04_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_RISE,
        MEASURE,
        CALC,
        OUT,
        GAP
    } state_t;

    localparam logic [1:0] ERR_OK     = 2'b00;
    localparam logic [1:0] ERR_NOECHO = 2'b01;
    localparam logic [1:0] ERR_RANGE  = 2'b10;

    // 0.1715 mm per us of echo, Q16 fixed point
    localparam int MM_PER_US_Q16 = 11239;
    localparam int MM_Q16_W      = 14;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sr04_us_tick.sv
// One-cycle pulse every microsecond; a reset pulse restarts the phase.
module sr04_us_tick #(
    parameter int CLK_FREQ_HZ = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    output logic us_tick
);

    localparam int DIV_RAW = CLK_FREQ_HZ / 1_000_000;
    localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;

    logic [DW-1:0] div_q, div_d;

    always_comb begin
        us_tick = (div_q == DW'(DIV - 1));
        div_d   = div_q + DW'(1);
        if (us_tick) begin
            div_d = '0;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/multi_sr04_ranger.sv
// Round-robin scheduler for HC-SR04 sensors: triggers each sensor in
// turn, times its echo and presents the distance in mm with a handshake.
module multi_sr04_ranger
    import sr04_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int NUM_CH      = 4,
    parameter int TRIG_US     = 10,
    parameter int RISE_TO_US  = 2000,
    parameter int ECHO_TO_US  = 38000,
    parameter int GAP_US      = 60000,
    parameter int DIST_W      = 16
) (
    input  logic                                          sys_clk,
    input  logic                                          sys_rst,
    input  logic                                          en,
    input  logic [NUM_CH-1:0]                             echo,
    output logic [NUM_CH-1:0]                             trig,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] res_ch,
    output logic [DIST_W-1:0]                             res_dist,
    output logic [1:0]                                    res_err
);

    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int CNT_MAX = max_int(max_int(TRIG_US, RISE_TO_US),
                                     max_int(ECHO_TO_US, GAP_US));
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PROD_W  = max_int(CNT_W + MM_Q16_W, DIST_W + 1);

    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_US - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_TO_US - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_US - 1);

    state_t              state_q, state_d;
    logic [CH_W-1:0]     cur_ch_q, cur_ch_d, ch_next;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]          err_q, err_d;
    logic [NUM_CH-1:0]   sync1_q, sync2_q;
    logic [NUM_CH-1:0]   trig_q, trig_d;
    logic                res_valid_q, res_valid_d;
    logic [CH_W-1:0]     res_ch_q, res_ch_d;
    logic [DIST_W-1:0]   res_dist_q, res_dist_d;
    logic [1:0]          res_err_q, res_err_d;

    logic                us_tick;
    logic                tick_clr;
    logic                echo_s;
    logic [PROD_W-1:0]   prod, scaled;
    logic [DIST_W-1:0]   dist_sat;

    // Tick phase restarts on every state change so us windows are exact
    sr04_us_tick #(
        .CLK_FREQ_HZ(CLK_FREQ_HZ)
    ) u_tick (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst | tick_clr),
        .us_tick(us_tick)
    );

    assign echo_s  = sync2_q[cur_ch_q];
    assign ch_next = (cur_ch_q == CH_W'(NUM_CH - 1)) ? '0 : cur_ch_q + CH_W'(1);

    always_comb begin
        prod     = PROD_W'(cnt_q) * PROD_W'(MM_PER_US_Q16);
        scaled   = prod >> 16;
        dist_sat = (|scaled[PROD_W-1:DIST_W]) ? '1 : scaled[DIST_W-1:0];
    end

    always_comb begin
        state_d     = state_q;
        cur_ch_d    = cur_ch_q;
        err_d       = err_q;
        cnt_d       = us_tick ? cnt_q + CNT_W'(1) : cnt_q;
        res_valid_d = res_valid_q;
        res_ch_d    = res_ch_q;
        res_dist_d  = res_dist_q;
        res_err_d   = res_err_q;
        unique case (state_q)
            IDLE: begin
                if (en) state_d = TRIG;
            end
            TRIG: begin
                if (us_tick && cnt_q == TRIG_LAST) state_d = WAIT_RISE;
            end
            WAIT_RISE: begin
                if (echo_s) begin
                    state_d = MEASURE;
                end else if (us_tick && cnt_q == RISE_LAST) begin
                    state_d = CALC;
                    err_d   = ERR_NOECHO;
                end
            end
            MEASURE: begin
                if (!echo_s) begin
                    state_d = CALC;
                    err_d   = ERR_OK;
                    cnt_d   = cnt_q;
                end else if (us_tick && cnt_q == ECHO_LAST) begin
                    state_d = CALC;
                    err_d   = ERR_RANGE;
                end
            end
            CALC: begin
                res_valid_d = 1'b1;
                res_ch_d    = cur_ch_q;
                res_err_d   = err_q;
                res_dist_d  = (err_q == ERR_OK) ? dist_sat : '1;
                state_d     = OUT;
            end
            OUT: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                if (us_tick && cnt_q == GAP_LAST) begin
                    cur_ch_d = ch_next;
                    state_d  = en ? TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        tick_clr = (state_d != state_q);
        // CALC still needs the echo count, so only timed states start at zero
        if (tick_clr && state_d inside {TRIG, WAIT_RISE, MEASURE, GAP}) begin
            cnt_d = '0;
        end
        trig_d = (state_d == TRIG) ? (NUM_CH'(1) << cur_ch_d) : '0;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q     <= IDLE;
            cur_ch_q    <= '0;
            cnt_q       <= '0;
            err_q       <= ERR_OK;
            sync1_q     <= '0;
            sync2_q     <= '0;
            trig_q      <= '0;
            res_valid_q <= 1'b0;
            res_ch_q    <= '0;
            res_dist_q  <= '0;
            res_err_q   <= ERR_OK;
        end else begin
            state_q     <= state_d;
            cur_ch_q    <= cur_ch_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
            sync1_q     <= echo;
            sync2_q     <= sync1_q;
            trig_q      <= trig_d;
            res_valid_q <= res_valid_d;
            res_ch_q    <= res_ch_d;
            res_dist_q  <= res_dist_d;
            res_err_q   <= res_err_d;
        end
    end

    assign trig      = trig_q;
    assign res_valid = res_valid_q;
    assign res_ch    = res_ch_q;
    assign res_dist  = res_dist_q;
    assign res_err   = res_err_q;

endmodule
